// File: rtl/uart_rx_if.sv
// uart_rx_if: serial pin plus received-byte / status strobes of the UART receiver.
// Latency: none, wires only.
// Backpressure: none; the receiver side only produces single-cycle strobes.
interface uart_rx_if;
   logic       uart_rxd;
   logic [7:0] uart_dout;
   logic       uart_rx_done;
   logic       uart_rx_busy;
   logic       uart_frame_err;
   logic       uart_parity_err;

   // line driver / byte consumer side
   modport master (
      output uart_rxd,
      input  uart_dout, uart_rx_done, uart_rx_busy, uart_frame_err, uart_parity_err
   );

   // receiver side
   modport slave (
      input  uart_rxd,
      output uart_dout, uart_rx_done, uart_rx_busy, uart_frame_err, uart_parity_err
   );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, idle-high; `UART_RX_PARITY_EN adds an even parity bit.
// Latency: done 3 + 9*BPS_CNT + BPS_CNT/2 cycles after the pin falls (+BPS_CNT with parity).
// Backpressure: none; done/frame_err/parity_err are one-cycle strobes, uart_dout holds until next good byte.
module uart_rx #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int UART_BPS   = 1_000_000
) (
   input  logic     sys_clk,
   input  logic     sys_rst_n,
   uart_rx_if.slave rx
);

   // sys_clk cycles per bit; values below 8 are not supported
   localparam int          BPS_CNT = CLOCK_FREQ / UART_BPS;
   localparam logic [15:0] BPS_MAX = 16'(BPS_CNT - 1);
   localparam logic [15:0] BPS_MID = 16'(BPS_CNT / 2);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
   } state_t;

   state_t      state;
   logic        rxd_d0;
   logic        rxd_d1;
   logic [15:0] bps_cnt;
   logic [2:0]  bit_cnt;
   logic [7:0]  rx_shift;
   logic [7:0]  dout;
   logic        done;
   logic        busy;
   logic        frame_err;
   logic        sample;

   // mid-bit strike point of the bit timer
   assign sample = (bps_cnt == BPS_MID);

   // two-flop synchroniser for the asynchronous pin; resets to the idle level
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rxd_d0 <= 1'b1;
         rxd_d1 <= 1'b1;
      end else begin
         rxd_d0 <= rx.uart_rxd;
         rxd_d1 <= rxd_d0;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic parity_bad;
   logic parity_err;
`endif

   // frame FSM, bit timer, shift register and registered strobes
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= IDLE;
         bps_cnt    <= '0;
         bit_cnt    <= '0;
         rx_shift   <= '0;
         dout       <= '0;
         done       <= 1'b0;
         busy       <= 1'b0;
         frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_bad <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         done      <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         // busy trails the return to IDLE by one cycle so it still covers the done cycle
         busy <= (state != IDLE);
         if (state != IDLE) begin
            bps_cnt <= (bps_cnt == BPS_MAX) ? 16'd0 : bps_cnt + 16'd1;
         end
         case (state)
            IDLE: begin
               if (rxd_d1 && !rxd_d0) begin
                  state   <= START;
                  bps_cnt <= '0;
                  bit_cnt <= '0;
                  busy    <= 1'b1;
               end
            end
            START: begin
               if (sample) begin
                  // a start bit that is high again at mid-bit was only a glitch
                  state <= rxd_d1 ? IDLE : DATA;
               end
            end
            DATA: begin
               if (sample) begin
                  rx_shift[bit_cnt] <= rxd_d1;
                  bit_cnt           <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (sample) begin
                  parity_bad <= ^{rx_shift, rxd_d1};
                  state      <= STOP;
               end
            end
`endif
            STOP: begin
               if (sample) begin
                  // finishing at mid-stop leaves half a bit to catch a back-to-back start
                  if (rxd_d1) begin
                     state <= IDLE;
`ifdef UART_RX_PARITY_EN
                     if (parity_bad) begin
                        parity_err <= 1'b1;
                     end else begin
                        dout <= rx_shift;
                        done <= 1'b1;
                     end
`else
                     dout <= rx_shift;
                     done <= 1'b1;
`endif
                  end else begin
                     frame_err <= 1'b1;
                     state     <= WAIT_IDLE;
                  end
               end
            end
            WAIT_IDLE: begin
               // a held-low line (break) must not be taken for a stream of new starts
               if (rxd_d1) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rx.uart_dout      = dout;
   assign rx.uart_rx_done   = done;
   assign rx.uart_rx_busy   = busy;
   assign rx.uart_frame_err = frame_err;
`ifdef UART_RX_PARITY_EN
   assign rx.uart_parity_err = parity_err;
`else
   assign rx.uart_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives UART frames into uart_rx and scores done/frame_err/parity_err strobes.
// Latency: expected strobe cycle derived from the cycle the start bit is driven.
// Backpressure: none; every strobe is popped from its expectation queue when seen.
module tb_uart_rx;
   localparam int BPS = 50;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
   localparam int LAT    = 528;
`else
   localparam bit PAR_EN = 1'b0;
   localparam int LAT    = 478;
`endif

   logic sys_clk   = 1'b0;
   logic sys_rst_n = 1'b0;

   uart_rx_if rxif();

   uart_rx #(
      .CLOCK_FREQ(50_000_000),
      .UART_BPS  (1_000_000)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .rx       (rxif)
   );

   always #10 sys_clk = ~sys_clk;

   // cycle index of the most recent rising edge
   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int checks = 0;
   int passed = 0;

   function automatic void check(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endfunction

   typedef struct {
      logic [7:0] data;
      int         at;
   } exp_t;

   exp_t done_q[$];
   int   ferr_q[$];
   int   perr_q[$];

   // number of falling edges at which busy was seen high
   int busy_hi = 0;
   always @(negedge sys_clk) if (rxif.uart_rx_busy) busy_hi <= busy_hi + 1;

   // scoreboard: every strobe must match the oldest expectation of its kind
   always @(negedge sys_clk) begin : mon
      exp_t e;
      int   at;
      if (sys_rst_n) begin
         if (rxif.uart_rx_done) begin
            check("done_expected", int'(done_q.size() > 0), 1);
            check("done_ferr_exclusive", int'(rxif.uart_frame_err), 0);
            if (done_q.size() > 0) begin
               e = done_q.pop_front();
               check("done_data", int'(rxif.uart_dout), int'(e.data));
               check("done_cycle", cyc, e.at);
            end
         end
         if (rxif.uart_frame_err) begin
            check("ferr_expected", int'(ferr_q.size() > 0), 1);
            if (ferr_q.size() > 0) begin
               at = ferr_q.pop_front();
               check("ferr_cycle", cyc, at);
            end
         end
         if (rxif.uart_parity_err) begin
            check("perr_expected", int'(perr_q.size() > 0), 1);
            if (perr_q.size() > 0) begin
               at = perr_q.pop_front();
               check("perr_cycle", cyc, at);
            end
         end
      end
   end

   task automatic drive_bit(input logic b);
      rxif.uart_rxd = b;
      repeat (BPS) @(negedge sys_clk);
   endtask

   // called on a falling edge; returns on the falling edge that ends the stop bit
   task automatic send_frame(input logic [7:0] d, input logic stop_b, input bit par_good);
      bit ok_par;
      exp_t e;
      ok_par = par_good || !PAR_EN;
      if (!stop_b) ferr_q.push_back(cyc + LAT);
      else if (!ok_par) perr_q.push_back(cyc + LAT);
      else begin
         e.data = d;
         e.at   = cyc + LAT;
         done_q.push_back(e);
      end
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (PAR_EN) drive_bit(par_good ? ^d : ~^d);
      drive_bit(stop_b);
   endtask

   typedef struct {
      logic [7:0] data;
      bit         par_good;
      int         gap;
   } vec_t;

   initial begin : watchdog
      repeat (60000) @(posedge sys_clk);
      $display("FAIL watchdog: simulation did not finish within 60000 cycles");
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t       vecs[5];
      int         snap;
      logic [7:0] c3;
      logic [7:0] held;

      vecs[0] = '{8'h00, 1'b1, 0};     // no gap: next frame starts right after the stop bit
      vecs[1] = '{8'hFF, 1'b1, 50};
      vecs[2] = '{8'h07, 1'b0, 50};    // wrong parity when parity is built in
      vecs[3] = '{8'h07, 1'b1, 50};
      vecs[4] = '{8'h5A, 1'b1, 10};

      rxif.uart_rxd = 1'b1;
      repeat (3) @(negedge sys_clk);
      check("rst_dout", int'(rxif.uart_dout), 0);
      check("rst_done", int'(rxif.uart_rx_done), 0);
      check("rst_busy", int'(rxif.uart_rx_busy), 0);
      check("rst_ferr", int'(rxif.uart_frame_err), 0);
      check("rst_perr", int'(rxif.uart_parity_err), 0);
      sys_rst_n = 1'b1;
      repeat (BPS) @(negedge sys_clk);

      // 0xA5: busy from detection up to and including the done cycle
      snap = busy_hi;
      send_frame(8'hA5, 1'b1, 1'b1);
      @(negedge sys_clk);
      check("a5_busy_cycles", busy_hi - snap, LAT - 1);
      check("a5_busy_idle", int'(rxif.uart_rx_busy), 0);
      check("a5_dout_held", int'(rxif.uart_dout), 8'hA5);

      for (int v = 0; v < 5; v++) begin
         send_frame(vecs[v].data, 1'b1, vecs[v].par_good);
         repeat (vecs[v].gap) @(negedge sys_clk);
      end
      check("table_dout_last", int'(rxif.uart_dout), 8'h5A);

      // 10-cycle low glitch: a false start, busy for 27 cycles
      snap = busy_hi;
      rxif.uart_rxd = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge sys_clk);
         if (k == 10) rxif.uart_rxd = 1'b1;
      end
      check("glitch_busy_cycles", busy_hi - snap, 27);
      check("glitch_dout", int'(rxif.uart_dout), 8'h5A);

      // 0x55 with a low stop bit, then line held low as a break
      send_frame(8'h55, 1'b0, 1'b1);
      repeat (200) @(negedge sys_clk);
      check("break_busy", int'(rxif.uart_rx_busy), 1);
      rxif.uart_rxd = 1'b1;
      repeat (2) @(negedge sys_clk);
      check("break_busy_2cyc", int'(rxif.uart_rx_busy), 1);
      repeat (2) @(negedge sys_clk);
      check("break_busy_released", int'(rxif.uart_rx_busy), 0);
      check("break_dout_held", int'(rxif.uart_dout), 8'h5A);
      repeat (BPS) @(negedge sys_clk);
      send_frame(8'h3C, 1'b1, 1'b1);
      repeat (BPS) @(negedge sys_clk);

      // 0xC3 cut by a reset in the middle of bit 4; the rest of the frame is dropped
      c3 = 8'hC3;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(c3[i]);
      rxif.uart_rxd = c3[4];
      repeat (BPS / 2) @(negedge sys_clk);
      held = rxif.uart_dout;
      check("pre_reset_dout", int'(held), 8'h3C);
      sys_rst_n = 1'b0;
      repeat (2) @(negedge sys_clk);
      check("midrst_dout", int'(rxif.uart_dout), 0);
      check("midrst_busy", int'(rxif.uart_rx_busy), 0);
      check("midrst_done", int'(rxif.uart_rx_done), 0);
      check("midrst_ferr", int'(rxif.uart_frame_err), 0);
      check("midrst_perr", int'(rxif.uart_parity_err), 0);
      rxif.uart_rxd = 1'b1;
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (20 * BPS) @(negedge sys_clk);
      check("postrst_busy", int'(rxif.uart_rx_busy), 0);
      check("postrst_dout", int'(rxif.uart_dout), 0);
      send_frame(8'h81, 1'b1, 1'b1);
      check("postrst_dout_81", int'(rxif.uart_dout), 8'h81);

      for (int k = 0; k < 2000 && (done_q.size() + ferr_q.size() + perr_q.size()) > 0; k++)
         @(negedge sys_clk);
      check("pending_done", done_q.size(), 0);
      check("pending_ferr", ferr_q.size(), 0);
      check("pending_perr", perr_q.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
